// File: rtl/apb_uart_csr_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_uart_csr_if
// Description : APB3 bus bundle for the UART control/status register block.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_uart_csr_if #(
  parameter int ADDR_W = 12
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/apb_uart_csr.sv
`default_nettype none
// ============================================================================
// Module      : apb_uart_csr
// Description : APB3 control/status registers for the UART: baud divisor,
//               parity, stop bits, sticky W1C error status with maskable
//               irq, and optional saturating error counters.
//               Optional feature macro: APB_UART_CSR_ERRCNT_EN enables the
//               RX_ERR_CNT (0x14) and RX_DROP_CNT (0x18) counters.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_uart_csr #(
  parameter int ADDR_W  = 12,
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 54,
  parameter int CNT_W   = 16,
  parameter int WAIT    = 0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  apb_uart_csr_if.slave         bus,
  input  wire logic             rx_err,
  input  wire logic             rx_drop,
  input  wire logic             tx_busy,
  output logic [DIV_W-1:0]      divisor,
  output logic [1:0]            parity_mode,
  output logic                  stop_two,
  output logic                  irq
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ACCESS = 2'd1;
  localparam logic [1:0] c_ST_DONE   = 2'd2;

  localparam logic [1:0] c_WAIT = 2'(WAIT);

  localparam logic [ADDR_W-1:0] c_A_DIV    = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] c_A_PARITY = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] c_A_STOP   = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] c_A_STATUS = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] c_A_IRQEN  = ADDR_W'(8'h10);
`ifdef APB_UART_CSR_ERRCNT_EN
  localparam logic [ADDR_W-1:0] c_A_RXECNT = ADDR_W'(8'h14);
  localparam logic [ADDR_W-1:0] c_A_RXDCNT = ADDR_W'(8'h18);
`endif

  logic [1:0]       r_state;
  logic [1:0]       r_wait_cnt;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_parity;
  logic             r_stop;
  logic [1:0]       r_sts;
  logic [1:0]       r_irq_en;
  logic             r_irq;

  logic             w_map;
  logic             w_sel_div;
  logic             w_sel_par;
  logic             w_sel_stop;
  logic             w_sel_sts;
  logic             w_sel_irqen;
  logic [31:0]      w_rdata;
  logic             w_par_bad;
  logic             w_err;
  logic             w_done;
  logic             w_wr;
  logic [1:0]       w_w1c;

`ifdef APB_UART_CSR_ERRCNT_EN
  logic [CNT_W-1:0] r_cnt_err;
  logic [CNT_W-1:0] r_cnt_drop;
  logic             w_sel_rxe;
  logic             w_sel_rxd;
`endif

  // APB transfer sequencing: setup -> access (+wait states) -> done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_ST_IDLE;
      r_wait_cnt <= 2'd0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (bus.psel && !bus.penable) begin
            r_state    <= c_ST_ACCESS;
            r_wait_cnt <= c_WAIT;
          end
        end
        c_ST_ACCESS: begin
          if (!bus.psel) begin
            r_state <= c_ST_IDLE;
          end else if (r_wait_cnt == 2'd0) begin
            r_state <= c_ST_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Address decode and read-data mux; misaligned addresses never match
  always_comb begin
    w_map       = 1'b0;
    w_sel_div   = 1'b0;
    w_sel_par   = 1'b0;
    w_sel_stop  = 1'b0;
    w_sel_sts   = 1'b0;
    w_sel_irqen = 1'b0;
    w_rdata     = 32'd0;
`ifdef APB_UART_CSR_ERRCNT_EN
    w_sel_rxe   = 1'b0;
    w_sel_rxd   = 1'b0;
`endif
    case (bus.paddr)
      c_A_DIV:    begin w_map = 1'b1; w_sel_div   = 1'b1; w_rdata = 32'(r_div);    end
      c_A_PARITY: begin w_map = 1'b1; w_sel_par   = 1'b1; w_rdata = 32'(r_parity); end
      c_A_STOP:   begin w_map = 1'b1; w_sel_stop  = 1'b1; w_rdata = 32'(r_stop);   end
      c_A_STATUS: begin w_map = 1'b1; w_sel_sts   = 1'b1; w_rdata = 32'({tx_busy, r_sts}); end
      c_A_IRQEN:  begin w_map = 1'b1; w_sel_irqen = 1'b1; w_rdata = 32'(r_irq_en); end
`ifdef APB_UART_CSR_ERRCNT_EN
      c_A_RXECNT: begin w_map = 1'b1; w_sel_rxe   = 1'b1; w_rdata = 32'(r_cnt_err);  end
      c_A_RXDCNT: begin w_map = 1'b1; w_sel_rxd   = 1'b1; w_rdata = 32'(r_cnt_drop); end
`endif
      default: ;
    endcase
  end

  // Parity value 3 is reserved, so such a write is refused
  assign w_par_bad = bus.pwrite && w_sel_par && (bus.pwdata[1:0] == 2'd3);
  assign w_err     = !w_map || w_par_bad;
  assign w_done    = (r_state == c_ST_DONE);
  assign w_wr      = w_done && bus.pwrite && !w_err;
  assign w_w1c     = (w_wr && w_sel_sts) ? bus.pwdata[1:0] : 2'b00;

  // Response is combinational from live registers so a same-edge event is seen
  assign bus.pready  = w_done;
  assign bus.pslverr = w_done && w_err;
  assign bus.prdata  = (w_done && !bus.pwrite && !w_err) ? w_rdata : 32'd0;

  // Configuration registers, committed on the edge ending the DONE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= DIV_W'(DIV_RST);
      r_parity <= 2'd0;
      r_stop   <= 1'b0;
      r_irq_en <= 2'd0;
    end else if (w_wr) begin
      if (w_sel_div)   r_div    <= bus.pwdata[DIV_W-1:0];
      if (w_sel_par)   r_parity <= bus.pwdata[1:0];
      if (w_sel_stop)  r_stop   <= bus.pwdata[0];
      if (w_sel_irqen) r_irq_en <= bus.pwdata[1:0];
    end
  end

  // Sticky error status: event set takes priority over write-1-to-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sts <= 2'b00;
    end else begin
      r_sts[0] <= rx_err  | (r_sts[0] & ~w_w1c[0]);
      r_sts[1] <= rx_drop | (r_sts[1] & ~w_w1c[1]);
    end
  end

  // Registered level interrupt from masked sticky status
  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= |(r_sts & r_irq_en);
  end

`ifdef APB_UART_CSR_ERRCNT_EN
  // Saturating error counters; a clear coinciding with an event leaves 1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_err  <= '0;
      r_cnt_drop <= '0;
    end else begin
      if (w_wr && w_sel_rxe)  r_cnt_err <= CNT_W'(rx_err);
      else if (rx_err && (r_cnt_err != {CNT_W{1'b1}}))
        r_cnt_err <= r_cnt_err + CNT_W'(1);
      if (w_wr && w_sel_rxd)  r_cnt_drop <= CNT_W'(rx_drop);
      else if (rx_drop && (r_cnt_drop != {CNT_W{1'b1}}))
        r_cnt_drop <= r_cnt_drop + CNT_W'(1);
    end
  end
`endif

  assign divisor     = r_div;
  assign parity_mode = r_parity;
  assign stop_two    = r_stop;
  assign irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_csr.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_uart_csr
// Description : Self-checking bench for apb_uart_csr (WAIT=0 main instance,
//               WAIT=2 instance for latency). Honours APB_UART_CSR_ERRCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_uart_csr;

`ifdef APB_UART_CSR_ERRCNT_EN
  localparam bit c_CNT_ON = 1'b1;
`else
  localparam bit c_CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_err = 1'b0, rx_drop = 1'b0, tx_busy = 1'b0;
  logic [15:0] divisor, divisor2;
  logic [1:0]  parity_mode, parity_mode2;
  logic        stop_two, stop_two2, irq, irq2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_uart_csr_if #(.ADDR_W(12)) bus ();
  apb_uart_csr_if #(.ADDR_W(12)) bus2 ();

  assign bus2.psel    = bus.psel;
  assign bus2.penable = bus.penable;
  assign bus2.pwrite  = bus.pwrite;
  assign bus2.paddr   = bus.paddr;
  assign bus2.pwdata  = bus.pwdata;

  apb_uart_csr #(.ADDR_W(12), .DIV_W(16), .DIV_RST(54), .CNT_W(4), .WAIT(0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .rx_err(rx_err), .rx_drop(rx_drop),
    .tx_busy(tx_busy), .divisor(divisor), .parity_mode(parity_mode),
    .stop_two(stop_two), .irq(irq));

  apb_uart_csr #(.ADDR_W(12), .DIV_W(16), .DIV_RST(54), .CNT_W(4), .WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .rx_err(rx_err), .rx_drop(rx_drop),
    .tx_busy(tx_busy), .divisor(divisor2), .parity_mode(parity_mode2),
    .stop_two(stop_two2), .irq(irq2));

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                              input bit c, input logic [31:0] rd, input bit e);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.chk_rd = c; v.exp_rd = rd; v.exp_err = e;
    return v;
  endfunction

  // One APB transfer; optional event pulses land on the committing edge
  task automatic apb(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                     input bit use2, input bit ev_err, input bit ev_drop,
                     output logic [31:0] rd, output logic err, output int lat);
    bit done;
    done = 1'b0;
    rd   = 32'hDEAD_BEEF;
    err  = 1'bx;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wd;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      if (use2 ? bus2.pready : bus.pready) begin
        done = 1'b1;
        rd   = use2 ? bus2.prdata  : bus.prdata;
        err  = use2 ? bus2.pslverr : bus.pslverr;
        if (ev_err)  rx_err  = 1'b1;
        if (ev_drop) rx_drop = 1'b1;
      end else begin
        lat++;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL apb_timeout: got no pready expected pready within 20 cycles");
    end
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; rx_err = 1'b0; rx_drop = 1'b0;
  endtask

  task automatic pulse(input bit e, input bit d);
    @(posedge clk); #1;
    rx_err = e; rx_drop = d;
    @(posedge clk); #1;
    rx_err = 1'b0; rx_drop = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  bit          seen;

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;

    vt[0]  = mk(0, 12'h000, 0,            1, 32'd54,   0);
    vt[1]  = mk(1, 12'h004, 2,            0, 0,        0);
    vt[2]  = mk(0, 12'h004, 0,            1, 32'd2,    0);
    vt[3]  = mk(1, 12'h004, 3,            0, 0,        1);
    vt[4]  = mk(0, 12'h004, 0,            1, 32'd2,    0);
    vt[5]  = mk(1, 12'h000, 32'h1234,     0, 0,        0);
    vt[6]  = mk(0, 12'h000, 0,            1, 32'h1234, 0);
    vt[7]  = mk(1, 12'h008, 32'hFFFFFFFF, 0, 0,        0);
    vt[8]  = mk(0, 12'h008, 0,            1, 32'd1,    0);
    vt[9]  = mk(1, 12'h010, 32'hFF,       0, 0,        0);
    vt[10] = mk(0, 12'h010, 0,            1, 32'd3,    0);
    vt[11] = mk(0, 12'h020, 0,            1, 32'd0,    1);
    vt[12] = mk(0, 12'h006, 0,            1, 32'd0,    1);
    vt[13] = mk(1, 12'h020, 5,            0, 0,        1);
    vt[14] = mk(1, 12'h002, 32'hBEEF,     0, 0,        1);
    vt[15] = mk(0, 12'h000, 0,            1, 32'h1234, 0);
    vt[16] = mk(0, 12'h00C, 0,            1, 32'd0,    0);
    vt[17] = mk(0, 12'h014, 0,            1, 32'd0,    !c_CNT_ON);
    vt[18] = mk(1, 12'h018, 0,            0, 0,        !c_CNT_ON);
    vt[19] = mk(0, 12'h0FC, 0,            1, 32'd0,    1);

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_prdata",  bus.prdata,  32'd0);
    chk("rst_pready",  32'(bus.pready),  32'd0);
    chk("rst_pslverr", 32'(bus.pslverr), 32'd0);
    chk("rst_irq",     32'(irq),    32'd0);
    chk("rst_divisor", 32'(divisor), 32'd54);
    chk("rst_parity",  32'(parity_mode), 32'd0);
    chk("rst_stop",    32'(stop_two), 32'd0);

    // WAIT=2 latency: pready in cycle 4
    apb(0, 12'h000, 0, 1, 0, 0, rd, err, lat);
    chk("w2_lat",    32'(lat), 32'd4);
    chk("w2_prdata", rd, 32'd54);
    chk("w2_err",    32'(err), 32'd0);

    // Table-driven register map on the WAIT=0 instance
    for (int i = 0; i < 20; i++) begin
      apb(vt[i].wr, vt[i].addr, vt[i].wdata, 0, 0, 0, rd, err, lat);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
      if (vt[i].chk_rd) chk($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].exp_err));
    end
    @(negedge clk);
    chk("out_divisor", 32'(divisor), 32'h1234);
    chk("out_parity",  32'(parity_mode), 32'd2);
    chk("out_stop",    32'(stop_two), 32'd1);

    // Sticky status and irq timing
    apb(1, 12'h010, 1, 0, 0, 0, rd, err, lat);
    pulse(1, 0);
    @(negedge clk);
    chk("irq_lag", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'd1);
    apb(0, 12'h00C, 0, 0, 0, 0, rd, err, lat);
    chk("sts_err", rd, 32'd1);
    tx_busy = 1'b1;
    apb(0, 12'h00C, 0, 0, 0, 0, rd, err, lat);
    chk("sts_busy", rd, 32'd5);
    tx_busy = 1'b0;
    apb(1, 12'h00C, 1, 0, 1, 0, rd, err, lat);
    apb(0, 12'h00C, 0, 0, 0, 0, rd, err, lat);
    chk("w1c_set_wins", rd, 32'd1);
    chk("irq_kept", 32'(irq), 32'd1);
    apb(1, 12'h00C, 1, 0, 0, 0, rd, err, lat);
    @(negedge clk);
    chk("irq_clr_lag", 32'(irq), 32'd1);
    @(negedge clk);
    chk("irq_clr", 32'(irq), 32'd0);
    apb(0, 12'h00C, 0, 0, 0, 0, rd, err, lat);
    chk("sts_clr", rd, 32'd0);
    pulse(0, 1);
    apb(0, 12'h00C, 0, 0, 0, 0, rd, err, lat);
    chk("sts_drop", rd, 32'd2);
    chk("irq_masked", 32'(irq), 32'd0);
    apb(1, 12'h00C, 2, 0, 0, 0, rd, err, lat);
    apb(0, 12'h00C, 0, 0, 0, 0, rd, err, lat);
    chk("sts_drop_clr", rd, 32'd0);

    // Error counters (one rx_drop pulse already counted above)
    if (c_CNT_ON) begin
      for (int i = 0; i < 20; i++) pulse(0, 1);
      apb(0, 12'h018, 0, 0, 0, 0, rd, err, lat);
      chk("cnt_sat", rd, 32'd15);
      apb(0, 12'h014, 0, 0, 0, 0, rd, err, lat);
      chk("cnt_err", rd, 32'd2);
      apb(1, 12'h018, 0, 0, 0, 1, rd, err, lat);
      apb(0, 12'h018, 0, 0, 0, 0, rd, err, lat);
      chk("cnt_clr_ev", rd, 32'd1);
    end else begin
      apb(0, 12'h014, 0, 0, 0, 0, rd, err, lat);
      chk("cnt_off_err", 32'(err), 32'd1);
      chk("cnt_off_rd",  rd, 32'd0);
    end

    // Reset during the access phase of a DIV write
    seen = 1'b0;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 12'h000; bus.pwdata = 32'h1234;
    @(posedge clk); #1;
    bus.penable = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.pready) seen = 1'b1;
    end
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge clk);
    chk("rstx_pready", 32'(seen), 32'd0);
    chk("rstx_divisor", 32'(divisor), 32'd54);
    apb(0, 12'h000, 0, 0, 0, 0, rd, err, lat);
    chk("rstx_read", rd, 32'd54);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_uart_csr.md
# apb_uart_csr

Parametrised APB3 control/status register block for the UART. Supersedes the fixed 32-bit register file with:
- proper APB3 handshake (`pready`, `pslverr`) and configurable wait states;
- sticky write-1-to-clear error status with a maskable interrupt;
- optional saturating error counters.

It sits between the APB interconnect and the `uart_rx`/`uart_tx` cores, driving their line configuration and collecting their error events.

## Interface
Parameters:
- `ADDR_W`, 12: number of `paddr` bits decoded.
- `DIV_W`, 16: baud divisor width.
- `DIV_RST`, 54: reset value of the divisor.
- `CNT_W`, 16: error counter width (1..32).
- `WAIT`, 0: APB wait states inserted per transfer (0..3).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `psel`, `penable`, `pwrite` in 1: APB3 control.
- `paddr` in `ADDR_W`: byte address.
- `pwdata` in 32: write data.
- `prdata` out 32: read data.
- `pready` out 1: transfer completion.
- `pslverr` out 1: transfer error.
- `rx_err` in 1: single-cycle pulse, framing/parity error from `uart_rx`.
- `rx_drop` in 1: single-cycle pulse, byte dropped from `uart_rx`.
- `tx_busy` in 1: live level from `uart_tx`.
- `divisor` out `DIV_W`: baud divisor to rx/tx.
- `parity_mode` out 2: 0 none, 1 even, 2 odd, 3 reserved.
- `stop_two` out 1: 0 = one stop bit, 1 = two stop bits.
- `irq` out 1: level interrupt, registered.

## Operation
Register map (`paddr[ADDR_W-1:0]`):
- 0x00 DIV, RW, bits `[DIV_W-1:0]`.
- 0x04 PARITY, RW, bits [1:0]. A write of value 3 is ignored and returns `pslverr`.
- 0x08 STOP, RW, bit 0.
- 0x0C STATUS:
  - bit0 `rx_err_sticky` (W1C);
  - bit1 `rx_drop_sticky` (W1C);
  - bit2 `tx_busy` (RO, live).
- 0x10 IRQ_EN, RW, bits [1:0].
- 0x14 RX_ERR_CNT and 0x18 RX_DROP_CNT: present only with the macro (see Configuration). RO-saturating; any write clears.

Register rules:
- Unused bits read 0.
- Unmapped address, or `paddr[1:0]` ≠ 0: `pslverr` = 1, read returns 0, no state change.

APB FSM: IDLE → ACCESS → (WAIT count) → DONE → IDLE.
- IDLE: `psel & !penable` is the setup phase; the next cycle with `psel & penable` enters ACCESS.
- ACCESS: counter loads `WAIT`, decrements to 0.
- DONE: `pready` = 1 for exactly one cycle. `prdata`/`pslverr` are valid in that cycle.
- The write commits on the rising edge that ends the DONE cycle.
- `psel` dropping before DONE aborts to IDLE with no write and no pulse on `pready`.

Status and interrupt:
- Sticky bits set on their event pulse.
- A same-cycle event and W1C leaves the bit set: set wins.
- `irq` = registered `|(status[1:0] & irq_en)`.

Counters:
- Increment on the event pulse; saturate at all-ones.
- Same-cycle clear and event gives a result of 1.

## Timing
- Reset values: `prdata` 0, `pready` 0, `pslverr` 0, `irq` 0, `divisor` `DIV_RST`, `parity_mode` 0, `stop_two` 0, sticky bits 0, IRQ_EN 0, counters 0. FSM resets to IDLE.
- `rst` asserted mid-transfer: FSM returns to IDLE, no write, `pready` low next cycle.
- Transfer latency from the setup phase: `pready` high in cycle `2 + WAIT`, where the setup cycle = cycle 0 and the first access cycle = cycle 1.
- Config outputs update the cycle after the committing edge.
- `irq` follows a status or IRQ_EN change by one cycle.
- Event pulse at edge N: sticky bit and counter visible from cycle N+1. A read completing in cycle N+1 returns the new value.

## Configuration
- `APB_UART_CSR_ERRCNT_EN` defined:
  - RX_ERR_CNT/RX_DROP_CNT exist at 0x14/0x18, `CNT_W` bits, saturating.
- Not defined:
  - counters are not instantiated;
  - 0x14/0x18 are unmapped: read 0 with `pslverr` = 1, writes return `pslverr` = 1.

## Test plan
- Reset, then read DIV with `WAIT`=0 → `prdata` = 54, `pready` in cycle 2, `pslverr` = 0. With `WAIT`=2 → `pready` in cycle 4.
- Write PARITY = 2, read back → 2 and `parity_mode` = 2 next cycle. Write PARITY = 3 → `pslverr` = 1, `parity_mode` stays 2.
- Pulse `rx_err` with IRQ_EN = 1 → STATUS = 0x1 and `irq` = 1 one cycle later. Write 0x1 to STATUS in the same cycle as a new `rx_err` pulse → bit stays 1. Clear with no event → `irq` = 0 one cycle later.
- Read 0x20 and 0x06 → `prdata` = 0, `pslverr` = 1, no register changes.
- Macro on, `CNT_W`=4: 20 `rx_drop` pulses → RX_DROP_CNT = 15. Write 0 to it in the same cycle as an event → 1. Macro off: read 0x14 → `pslverr` = 1.
- Assert `rst` during the access phase of a write of DIV = 0x1234 → `divisor` = 54, `pready` never asserted for that transfer.
